// File: rtl/ap_pkg.sv
// ap_pkg: shared width, saturation limits and FSM states for the saturating subtract-accumulator
package ap_pkg;
  localparam int AP_W = 68;
  localparam logic signed [AP_W-1:0] AP_MAX = {1'b0, {(AP_W-1){1'b1}}};
  localparam logic signed [AP_W-1:0] AP_MIN = {1'b1, {(AP_W-1){1'b0}}};
  typedef enum logic {ACCUM, DRAIN} state_t;
endpackage

// File: rtl/ap_subtractor.sv
// ap_subtractor: combinational a-b clamped to the signed W-bit range, with overflow flag
module ap_subtractor
  import ap_pkg::*;
(
  input  logic signed [AP_W-1:0] a,
  input  logic signed [AP_W-1:0] b,
  output logic signed [AP_W-1:0] z,
  output logic                   ovf
);
  logic signed [AP_W-1:0] d;
  logic pos, neg;
  assign d   = a - b;
  assign pos = !a[AP_W-1] && b[AP_W-1] && d[AP_W-1];
  assign neg = a[AP_W-1] && !b[AP_W-1] && !d[AP_W-1];
  assign ovf = pos || neg;
  assign z   = pos ? AP_MAX : neg ? AP_MIN : d;
endmodule

// File: rtl/ap_sat_sub_acc.sv
// ap_sat_sub_acc: streaming saturating subtract-accumulator; AP_SUB_BIAS_EN makes each burst's first beat load acc
module ap_sat_sub_acc
  import ap_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [AP_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [AP_W-1:0] out_data,
  output logic                   out_sat
);
  state_t state, state_n;
  logic signed [AP_W-1:0] acc, z, res;
  logic sat, ovf, step_ovf, fire;
  ap_subtractor u_sub (.a(acc), .b(in_data), .z(z), .ovf(ovf));
  assign fire = in_valid && in_ready;
`ifdef AP_SUB_BIAS_EN
  logic first;
  assign res      = first ? in_data : z;
  assign step_ovf = !first && ovf;
  always_ff @(posedge clk)
    first <= rst ? 1'b1 : fire ? in_last : first;
`else
  assign res      = z;
  assign step_ovf = ovf;
`endif
  always_ff @(posedge clk)
    state <= rst ? ACCUM : state_n;
  always_comb
    state_n = (state == ACCUM) ? ((fire && in_last) ? DRAIN : ACCUM) : (out_ready ? ACCUM : DRAIN);
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DRAIN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      sat      <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (fire) begin
      acc <= in_last ? '0 : res;
      sat <= in_last ? 1'b0 : (sat || step_ovf);
      if (in_last) begin
        out_data <= res;
        out_sat  <= sat || step_ovf;
      end
    end
  end
endmodule

// File: tb/tb_ap_sat_sub_acc.sv
// tb_ap_sat_sub_acc: directed and random checks of ap_sat_sub_acc against a wide-arithmetic model
module tb_ap_sat_sub_acc;
  import ap_pkg::*;
`ifdef AP_SUB_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_sat;
  logic signed [AP_W-1:0] in_data = '0, out_data;
  int checks = 0, failures = 0;
  bit run = 1'b0;
  always #5 clk = ~clk;

  ap_sat_sub_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat)
  );

  task automatic chk(input string n, input logic [AP_W-1:0] act, input logic [AP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference step: exact difference in a wider range, then clamp
  function automatic logic [AP_W:0] step(input logic signed [AP_W-1:0] a, input logic signed [AP_W-1:0] x,
                                         input bit first);
    logic signed [AP_W+1:0] wa, wx, wide;
    if (BIAS && first) return {1'b0, x};
    wa = a;
    wx = x;
    wide = wa - wx;
    if (wide > wa - wa + AP_MAX) return {1'b1, AP_MAX};
    if (wide < wa - wa + AP_MIN) return {1'b1, AP_MIN};
    return {1'b0, wide[AP_W-1:0]};
  endfunction

  logic signed [AP_W-1:0] m_acc = '0, m_out = '0;
  bit m_sat = 0, m_osat = 0, m_drain = 0, m_first = 1;
  logic [AP_W:0] so;
  always @(posedge clk) begin
    if (rst) begin
      m_acc <= '0; m_sat <= 0; m_out <= '0; m_osat <= 0; m_drain <= 0; m_first <= 1;
    end else if (m_drain) begin
      if (out_ready) m_drain <= 0;
    end else if (in_valid) begin
      so = step(m_acc, in_data, m_first);
      if (in_last) begin
        m_out <= so[AP_W-1:0]; m_osat <= m_sat | so[AP_W]; m_acc <= '0; m_sat <= 0;
        m_drain <= 1; m_first <= 1;
      end else begin
        m_acc <= so[AP_W-1:0]; m_sat <= m_sat | so[AP_W]; m_first <= 0;
      end
    end
  end

  always @(negedge clk) if (run) begin
    chk("cyc_in_ready", AP_W'(in_ready), AP_W'(!m_drain));
    chk("cyc_out_valid", AP_W'(out_valid), AP_W'(m_drain));
    chk("cyc_out_data", out_data, m_out);
    chk("cyc_out_sat", AP_W'(out_sat), AP_W'(m_osat));
  end

  task automatic send(input logic signed [AP_W-1:0] x, input bit last);
    in_valid = 1; in_data = x; in_last = last;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  // Called one step after the in_last handshake; holds the result for `hold` cycles under junk input
  task automatic expect_res(input string n, input logic signed [AP_W-1:0] d, input bit s, input int hold);
    chk({n, "_valid"}, AP_W'(out_valid), AP_W'(1));
    chk({n, "_data"}, out_data, d);
    chk({n, "_sat"}, AP_W'(out_sat), AP_W'(s));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_data = AP_W'($urandom); in_last = 1;
      @(posedge clk); #1;
      chk({n, "_hold_ready"}, AP_W'(in_ready), AP_W'(0));
      chk({n, "_hold_data"}, out_data, d);
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({n, "_done_valid"}, AP_W'(out_valid), AP_W'(0));
    chk({n, "_done_ready"}, AP_W'(in_ready), AP_W'(1));
  endtask

  function automatic logic signed [AP_W-1:0] pick();
    logic signed [AP_W-1:0] v;
    case ($urandom_range(0, 4))
      0: v = AP_MAX;
      1: v = AP_MIN;
      2: v = {$urandom, $urandom, $urandom};
      3: v = AP_MAX - AP_W'($urandom_range(0, 3));
      default: v = AP_W'(signed'($urandom_range(0, 40)) - 20);
    endcase
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    run = 1;
    chk("reset_ready", AP_W'(in_ready), AP_W'(1));
    chk("reset_valid", AP_W'(out_valid), AP_W'(0));
    chk("reset_data", out_data, '0);
    chk("reset_sat", AP_W'(out_sat), AP_W'(0));
    if (BIAS) begin
      send(10, 0); send(3, 1); expect_res("bias_10_3", 7, 0, 0);
      send(AP_MIN, 1); expect_res("bias_single_min", AP_MIN, 0, 0);
      send(AP_MIN, 0); send(1, 1); expect_res("bias_min_1", AP_MIN, 1, 0);
    end else begin
      send(5, 0); send(3, 1); expect_res("b_5_3", -8, 0, 0);
      send(AP_MAX, 0); send(5, 1); expect_res("b_max_5", AP_MIN, 1, 0);
      send(1, 1); expect_res("b_1_clear", -1, 0, 0);
      send(AP_MIN, 1); expect_res("b_single_min", AP_MAX, 1, 0);
    end
    send(6, 1); expect_res("hold", BIAS ? 68'sd6 : -68'sd6, 0, 3);
    send(2, 1); expect_res("after_hold", BIAS ? 68'sd2 : -68'sd2, 0, 0);
    send(7, 0); send(9, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_valid", AP_W'(out_valid), AP_W'(0));
    chk("rst_mid_ready", AP_W'(in_ready), AP_W'(1));
    chk("rst_mid_data", out_data, '0);
    chk("rst_mid_sat", AP_W'(out_sat), AP_W'(0));
    send(4, 1); expect_res("after_rst", BIAS ? 68'sd4 : -68'sd4, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = pick();
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 0; in_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
